// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline front end.
// Holds the bubble encoding, the fetch FSM states and a word-alignment helper.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > stall (hold) > load.
// When no word is offered, a bubble is inserted and the PC fields keep their old values.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= BUBBLE_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        instr    <= load_instr;
        pc       <= load_pc;
        pc_plus4 <= load_pc + XLEN'(4);
        valid    <= 1'b1;
      end else begin
        instr <= BUBBLE_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, skid buffer
// for words that arrive while decode is stalled, and the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state, state_next;
  logic [31:0]  pcf, pcf_next;
  logic [31:0]  skid_instr, skid_next;
  logic [31:0]  redirect_pc, redirect_next;
  logic         outstanding;
  logic         post_reset;
  logic         resp;
  logic         word_valid;
  logic [31:0]  word_instr;
  logic [31:0]  target;
  logic [31:0]  pcf_plus4;

  assign target    = align_word(PCTargetE);
  assign pcf_plus4 = pcf + 32'd4;
  assign imem_addr = pcf;

  // A request that is already in flight is kept alive even if StallF rises.
  assign imem_req = (state == DRAIN) || ((state == FETCH) && (outstanding || !StallF));
  assign resp     = imem_valid && imem_req && !post_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pcf         <= RESET_PC;
      skid_instr  <= NOP_INSTR;
      redirect_pc <= RESET_PC;
      outstanding <= 1'b0;
      post_reset  <= 1'b1;
    end else begin
      state       <= state_next;
      pcf         <= pcf_next;
      skid_instr  <= skid_next;
      redirect_pc <= redirect_next;
      outstanding <= imem_req && !resp;
      post_reset  <= 1'b0;
    end
  end

  always_comb begin
    state_next    = state;
    pcf_next      = pcf;
    skid_next     = skid_instr;
    redirect_next = redirect_pc;
    word_valid    = 1'b0;
    word_instr    = imem_rdata;
    case (state)
      FETCH: begin
        word_valid = resp;
        if (PCSrcE) begin
          // The memory still owes a response for the old address; wait it out.
          if (imem_req && !resp) begin
            redirect_next = target;
            state_next    = DRAIN;
          end else begin
            pcf_next = target;
          end
        end else if (resp) begin
          if (StallD) begin
            skid_next  = imem_rdata;
            state_next = HOLD;
          end else if (!StallF) begin
            pcf_next = pcf_plus4;
          end
        end
      end
      HOLD: begin
        word_valid = 1'b1;
        word_instr = skid_instr;
        if (PCSrcE) begin
          pcf_next   = target;
          state_next = FETCH;
        end else if (!StallD) begin
          state_next = FETCH;
          if (!StallF) pcf_next = pcf_plus4;
        end
      end
      DRAIN: begin
        if (PCSrcE) redirect_next = target;
        if (resp) begin
          pcf_next   = PCSrcE ? target : redirect_pc;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .stall     (StallD),
    .flush     (FlushD || PCSrcE),
    .load_valid(word_valid),
    .load_instr(word_instr),
    .load_pc   (pcf),
    .instr     (InstrD),
    .pc        (PCD),
    .pc_plus4  (PCPlus4D),
    .valid     (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, directed multi-cycle sequences,
// and a randomized run against a program-order model of the delivered instruction stream.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  // Instruction memory: the word at address a is a+0xA0; latency fixed or random 0..3.
  int   fixed_lat = 0;
  int   mem_cnt = 0;
  int   mem_lat = 0;
  logic stray = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  function automatic int pick_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endfunction

  assign imem_valid = (imem_req && (mem_cnt == mem_lat)) || stray;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (reset) begin
      mem_cnt <= 0;
      mem_lat <= pick_lat();
    end else if (imem_req && imem_valid) begin
      mem_cnt <= 0;
      mem_lat <= pick_lat();
    end else if (imem_req) begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  int          n_tests = 0;
  int          n_fail = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic sf, input logic sd, input logic fd,
                                input logic ps, input logic [31:0] tgt);
    StallF    = sf;
    StallD    = sd;
    FlushD    = fd;
    PCSrcE    = ps;
    PCTargetE = tgt;
  endtask

  // One clock: sample request side mid-cycle, then land 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = imem_valid;
    if (!reset) begin
      if (s_req) check_output("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
      if (pend && s_req) check_output("addr_stable", s_addr, pend_addr);
    end
    pend      = !reset && s_req && !s_valid;
    pend_addr = s_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    fixed_lat = lat;
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    check_output("rst_instr", InstrD, 32'h0000_0013);
    check_output("rst_pcd", PCD, 32'h0);
    check_output("rst_pcp4", PCPlus4D, 32'h0);
    check_bit("rst_valid", ValidD, 1'b0);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      if (ValidD) got = 1'b1;
    end
    check_bit("wait_valid_timeout", got, 1'b1);
  endtask

  typedef struct {
    logic        sf, sd, fd, ps;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vd;
    logic [31:0] pcd, p4;
  } vec_t;

  vec_t        vec[16];
  bit          got;
  int          deliveries;
  logic [31:0] exp_pc;
  logic        r_stall, r_ps;
  logic [31:0] r_tgt;

  initial begin
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'h0);

    // Zero-latency memory; first post-reset response is ignored by design.
    vec[0]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000};
    vec[1]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0004};
    vec[2]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0004, 32'h0000_0008};
    vec[3]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0008, 1, 32'h0000_0008, 32'h0000_000C};
    vec[4]  = '{1, 1, 0, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h0000_0008, 32'h0000_000C};
    vec[5]  = '{1, 1, 0, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h0000_0008, 32'h0000_000C};
    vec[6]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_000C, 1, 32'h0000_000C, 32'h0000_0010};
    vec[7]  = '{0, 0, 0, 1, 32'h103,      1, 32'h0000_0010, 0, 32'h0000_000C, 32'h0000_0010};
    vec[8]  = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0100, 1, 32'h0000_0100, 32'h0000_0104};
    vec[9]  = '{0, 0, 1, 0, 32'h0,        1, 32'h0000_0104, 0, 32'h0000_0100, 32'h0000_0104};
    vec[10] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0108, 1, 32'h0000_0108, 32'h0000_010C};
    vec[11] = '{0, 1, 0, 0, 32'h0,        1, 32'h0000_010C, 1, 32'h0000_0108, 32'h0000_010C};
    vec[12] = '{0, 0, 0, 0, 32'h0,        0, 32'h0000_010C, 1, 32'h0000_010C, 32'h0000_0110};
    vec[13] = '{0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0000_0110, 0, 32'h0000_010C, 32'h0000_0110};
    vec[14] = '{0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
    vec[15] = '{0, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0004};

    do_reset(0);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vec[i].sf, vec[i].sd, vec[i].fd, vec[i].ps, vec[i].tgt);
      tick();
      check_bit($sformatf("vec%0d_req", i), s_req, vec[i].req);
      check_output($sformatf("vec%0d_addr", i), s_addr, vec[i].addr);
      check_bit($sformatf("vec%0d_validd", i), ValidD, vec[i].vd);
      check_output($sformatf("vec%0d_pcd", i), PCD, vec[i].pcd);
      check_output($sformatf("vec%0d_pcp4", i), PCPlus4D, vec[i].p4);
      check_output($sformatf("vec%0d_instr", i), InstrD,
                   vec[i].vd ? mem_word(vec[i].pcd) : 32'h0000_0013);
    end

    // Latency 2: address held while waiting, bubbles between instructions.
    do_reset(2);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    tick(); tick(); tick();
    check_bit("lat2_first_valid", ValidD, 1'b1);
    check_output("lat2_first_pcd", PCD, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("lat2_addr_hold", s_addr, 32'h4);
      check_bit("lat2_validd", ValidD, (k == 2));
    end
    check_output("lat2_second_pcd", PCD, 32'h4);
    check_output("lat2_second_instr", InstrD, 32'hA4);
    check_output("lat2_second_pcp4", PCPlus4D, 32'h8);

    // Latency 1: word for 0x8 lands in the first of three stall cycles.
    do_reset(1);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    apply_stimulus(1, 1, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_bit("hold_req", s_req, (k == 0));
      check_output("hold_pcd", PCD, 32'h4);
      check_bit("hold_validd", ValidD, 1'b0);
    end
    apply_stimulus(0, 0, 0, 0, 32'h0);
    tick();
    check_output("release_pcd", PCD, 32'h8);
    check_output("release_instr", InstrD, 32'hA8);
    check_bit("release_validd", ValidD, 1'b1);
    tick();
    check_bit("release_next_req", s_req, 1'b1);
    check_output("release_next_addr", s_addr, 32'hC);

    // Latency 3: redirect to 0x100 while 0xC is outstanding.
    do_reset(3);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 12; k++) tick();
    check_output("drain_pre_pcd", PCD, 32'h8);
    apply_stimulus(0, 0, 0, 1, 32'h100);
    tick();
    check_output("drain_redirect_addr", s_addr, 32'hC);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_bit("drain_req", s_req, 1'b1);
      check_output("drain_addr", s_addr, 32'hC);
      check_bit("drain_validd", ValidD, 1'b0);
    end
    wait_valid(8, got);
    check_output("drain_target_pcd", PCD, 32'h100);
    check_output("drain_target_instr", InstrD, 32'h1A0);

    // Reset while draining, with a stray response right after reset.
    do_reset(3);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 12; k++) tick();
    apply_stimulus(0, 0, 0, 1, 32'h200);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    check_bit("rst_drain_req", s_req, 1'b1);
    check_output("rst_drain_addr", s_addr, 32'h0);
    check_bit("rst_drain_validd", ValidD, 1'b0);
    check_output("rst_drain_instr", InstrD, 32'h0000_0013);
    wait_valid(10, got);
    check_output("rst_drain_first_pcd", PCD, 32'h0);
    check_output("rst_drain_first_instr", InstrD, 32'hA0);

    // Random run: every delivered instruction must be the next one in program order.
    do_reset(-1);
    exp_pc     = 32'h0;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      r_stall = ($urandom_range(0, 99) < 20);
      r_ps    = ($urandom_range(0, 99) < 8);
      r_tgt   = $urandom;
      apply_stimulus(r_stall, r_stall, r_ps, r_ps, r_tgt);
      tick();
      if (r_ps) begin
        check_bit("rand_flush_bubble", ValidD, 1'b0);
        exp_pc = {r_tgt[31:2], 2'b00};
      end else if (ValidD && !r_stall) begin
        check_output("rand_pcd", PCD, exp_pc);
        check_output("rand_instr", InstrD, mem_word(exp_pc));
        check_output("rand_pcp4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end
    check_bit("rand_progress", (deliveries > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
